// File: rtl/sm3_pkg.sv
// Shared definitions for the SM3 message padder: FSM states, core command
// bit positions, the padding marker byte and the last-word padding helper.
package sm3_pkg;

    localparam int unsigned BLK_WORDS   = 16;
    localparam int unsigned CMD_RD      = 0;
    localparam int unsigned CMD_WR      = 1;
    localparam int unsigned CMD_CONT    = 2;
    localparam int unsigned STATUS_BUSY = 3;
    localparam logic [7:0]  PAD_BYTE    = 8'h80;

    typedef enum logic [3:0] {
        StIdle,
        StFill,
        StPad,
        StLen,
        StIssue,
        StStream,
        StWaitHi,
        StWaitLo,
        StRead
    } pad_state_e;

    // Keep the valid MSB-aligned bytes of the final word, drop 0x80 right
    // after them and zero the rest; a full word (0) passes through unchanged.
    function automatic logic [31:0] pad_last_word(input logic [31:0] data,
                                                  input logic [1:0]  nbytes);
        logic [31:0] w;
        case (nbytes)
            2'd1:    w = {data[31:24], PAD_BYTE, 16'h0000};
            2'd2:    w = {data[31:16], PAD_BYTE, 8'h00};
            2'd3:    w = {data[31:8], PAD_BYTE};
            default: w = data;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/sm3_blk_buf.sv
// 16x32 block buffer: indexed write port plus a sequential read pointer used
// to stream a completed block to the SM3 core.
module sm3_blk_buf
    import sm3_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [3:0]  wr_idx,
    input  logic [31:0] wr_data,
    input  logic        rd_start,
    input  logic        rd_adv,
    output logic [3:0]  rd_idx,
    output logic [31:0] rd_data
);

    logic [31:0] mem_q [BLK_WORDS];
    logic [3:0]  rd_ptr_q;

    // Word storage and read pointer; rd_start rewinds to word 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < BLK_WORDS; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_idx] <= wr_data;
            end
            if (rd_start) begin
                rd_ptr_q <= '0;
            end else if (rd_adv) begin
                rd_ptr_q <= rd_ptr_q + 4'd1;
            end
        end
    end

    assign rd_idx  = rd_ptr_q;
    assign rd_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/sm3_msg_padder.sv
// SM3 message padder: collects a big-endian word stream, applies SM3 padding
// (0x80, zero fill, 64-bit bit length) and feeds each 512-bit block to the
// compression core, waiting on the core's busy flag between blocks.
// Optional: define SM3_PAD_AUTO_READ_EN to issue the core read command
// together with done after the final block.
module sm3_msg_padder
    import sm3_pkg::*;
#(
    parameter int unsigned LEN_W = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    input  logic        s_last,
    input  logic [1:0]  s_nbytes,
    output logic        s_ready,
    output logic [31:0] core_din,
    output logic [2:0]  core_cmd,
    output logic        core_cmd_w,
    input  logic [3:0]  core_status,
    output logic        done,
    output logic        len_ovf
);

    localparam logic [4:0] WIDX_FULL = 5'd16;
    localparam logic [4:0] WIDX_LEN  = 5'd14;

    pad_state_e       state_q, state_d;
    logic [4:0]       widx_q, widx_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             len_ovf_q, len_ovf_d;
    logic             first_q, first_d;
    logic             final_q, final_d;
    logic             msg_end_q, msg_end_d;   // whole message received
    logic             pad80_q, pad80_d;       // 0x80 still owed as next word's MSB
    logic             ready_en_q;             // holds off s_ready until after reset

    logic             buf_we;
    logic [31:0]      buf_wdata;
    logic             rd_start, rd_adv;
    logic [3:0]       rd_idx;
    logic [31:0]      rd_data;

    logic [2:0]       nbytes_eff;
    logic [5:0]       add_bits;
    logic [LEN_W:0]   len_sum;
    logic [63:0]      len_field;
    logic             unused_status;

    assign unused_status = ^core_status[2:0];
    assign len_ovf       = len_ovf_q;

    sm3_blk_buf u_blk_buf (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (buf_we),
        .wr_idx   (widx_q[3:0]),
        .wr_data  (buf_wdata),
        .rd_start (rd_start),
        .rd_adv   (rd_adv),
        .rd_idx   (rd_idx),
        .rd_data  (rd_data)
    );

    // Bit-length bookkeeping: the adder's carry out flags counter wrap.
    always_comb begin
        nbytes_eff = (s_nbytes == 2'd0) ? 3'd4 : {1'b0, s_nbytes};
        add_bits   = s_last ? {nbytes_eff, 3'b000} : 6'd32;
        len_sum    = {1'b0, len_q} + (LEN_W + 1)'(add_bits);
        len_field  = '0;
        len_field[LEN_W-1:0] = len_q;
    end

    // State register and per-message context.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            widx_q     <= '0;
            len_q      <= '0;
            len_ovf_q  <= 1'b0;
            first_q    <= 1'b1;
            final_q    <= 1'b0;
            msg_end_q  <= 1'b0;
            pad80_q    <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            widx_q     <= widx_d;
            len_q      <= len_d;
            len_ovf_q  <= len_ovf_d;
            first_q    <= first_d;
            final_q    <= final_d;
            msg_end_q  <= msg_end_d;
            pad80_q    <= pad80_d;
            ready_en_q <= 1'b1;
        end
    end

    // Next-state, buffer writes and core interface outputs.
    always_comb begin
        state_d    = state_q;
        widx_d     = widx_q;
        len_d      = len_q;
        len_ovf_d  = len_ovf_q;
        first_d    = first_q;
        final_d    = final_q;
        msg_end_d  = msg_end_q;
        pad80_d    = pad80_q;
        buf_we     = 1'b0;
        buf_wdata  = '0;
        rd_start   = 1'b0;
        rd_adv     = 1'b0;
        s_ready    = 1'b0;
        core_din   = '0;
        core_cmd   = '0;
        core_cmd_w = 1'b0;
        done       = 1'b0;

        unique case (state_q)
            StIdle, StFill: begin
                s_ready = ready_en_q;
                if (s_valid && ready_en_q) begin
                    buf_we  = 1'b1;
                    widx_d  = widx_q + 5'd1;
                    len_d   = len_sum[LEN_W-1:0];
                    state_d = StFill;
                    if (len_sum[LEN_W]) begin
                        len_ovf_d = 1'b1;
                    end
                    if (s_last) begin
                        buf_wdata = pad_last_word(s_data, s_nbytes);
                        pad80_d   = (s_nbytes == 2'd0);
                        msg_end_d = 1'b1;
                        state_d   = StPad;
                    end else begin
                        buf_wdata = s_data;
                        if (widx_q == WIDX_FULL - 5'd1) begin
                            state_d = StIssue;
                        end
                    end
                end
            end
            StPad: begin
                if (widx_q == WIDX_FULL) begin
                    // Length does not fit: ship this block, pad a second one.
                    state_d = StIssue;
                end else if (pad80_q) begin
                    buf_we    = 1'b1;
                    buf_wdata = {PAD_BYTE, 24'h000000};
                    widx_d    = widx_q + 5'd1;
                    pad80_d   = 1'b0;
                end else if (widx_q == WIDX_LEN) begin
                    state_d = StLen;
                end else begin
                    buf_we = 1'b1;
                    widx_d = widx_q + 5'd1;
                end
            end
            StLen: begin
                buf_we    = 1'b1;
                buf_wdata = widx_q[0] ? len_field[31:0] : len_field[63:32];
                widx_d    = widx_q + 5'd1;
                if (widx_q[0]) begin
                    final_d = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                core_cmd_w         = 1'b1;
                core_cmd[CMD_WR]   = 1'b1;
                core_cmd[CMD_CONT] = ~first_q;
                rd_start           = 1'b1;
                state_d            = StStream;
            end
            StStream: begin
                core_din = rd_data;
                rd_adv   = 1'b1;
                if (rd_idx == 4'd15) begin
                    state_d = StWaitHi;
                end
            end
            StWaitHi: begin
                if (core_status[STATUS_BUSY]) begin
                    state_d = StWaitLo;
                end
            end
            StWaitLo: begin
                if (!core_status[STATUS_BUSY]) begin
                    first_d = 1'b0;
                    widx_d  = '0;
                    if (final_q) begin
                        first_d   = 1'b1;
                        len_d     = '0;
                        final_d   = 1'b0;
                        msg_end_d = 1'b0;
`ifdef SM3_PAD_AUTO_READ_EN
                        state_d   = StRead;
`else
                        done      = 1'b1;
                        state_d   = StIdle;
`endif
                    end else begin
                        state_d = msg_end_q ? StPad : StFill;
                    end
                end
            end
            StRead: begin
                core_cmd_w       = 1'b1;
                core_cmd[CMD_RD] = 1'b1;
                done             = 1'b1;
                state_d          = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_sm3_msg_padder.sv
// Testbench for sm3_msg_padder: random messages are padded by a byte-level
// reference model into expected blocks; a monitor that also plays the SM3
// core checks every issued block, the done pulse and s_ready back-pressure.
// Honours SM3_PAD_AUTO_READ_EN for the read command that accompanies done.
`timescale 1ns/1ps
module tb_sm3_msg_padder;

    localparam int unsigned LEN_W = 12;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic [1:0]  s_nbytes = '0;
    logic        s_ready;
    logic [31:0] core_din;
    logic [2:0]  core_cmd;
    logic        core_cmd_w;
    logic [3:0]  core_status = '0;
    logic        done;
    logic        len_ovf;

    sm3_msg_padder #(.LEN_W(LEN_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_last      (s_last),
        .s_nbytes    (s_nbytes),
        .s_ready     (s_ready),
        .core_din    (core_din),
        .core_cmd    (core_cmd),
        .core_cmd_w  (core_cmd_w),
        .core_status (core_status),
        .done        (done),
        .len_ovf     (len_ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         fin;
        logic [2:0]   cmd;
        logic [511:0] data;
    } blk_t;

    blk_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   done_cnt = 0;
    int   exp_done = 0;
    bit   ovf_exp = 1'b0;
    bit   last_fin = 1'b0;
    int   mon_phase = 0;
    int   mon_k = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic give_up(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out", name);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    endtask

    // Reference padding: bytes, 0x80, zeros to 56 mod 64, 8-byte bit length
    // (counter is LEN_W bits wide, so the field carries the length mod 2^LEN_W).
    task automatic push_model(input byte unsigned msg[$]);
        byte unsigned     p[$];
        longint unsigned  bits;
        longint unsigned  lenf;
        blk_t             b;
        int               nblk;
        p    = msg;
        bits = longint'(msg.size()) * 8;
        lenf = bits & ((64'd1 << LEN_W) - 1);
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(byte'(lenf >> (8 * i)));
        nblk = p.size() / 64;
        for (int blk = 0; blk < nblk; blk++) begin
            b.fin = (blk == nblk - 1);
            b.cmd = (blk == 0) ? 3'b010 : 3'b110;
            for (int j = 0; j < 64; j++) b.data[511 - 8 * j -: 8] = p[blk * 64 + j];
            exp_q.push_back(b);
        end
        if (bits >= (64'd1 << LEN_W)) ovf_exp = 1'b1;
        exp_done++;
    endtask

    task automatic send_msg(input byte unsigned msg[$]);
        int nw;
        nw = (msg.size() + 3) / 4;
        push_model(msg);
        for (int w = 0; w < nw; w++) begin
            logic [31:0] d;
            int          rem;
            bit          hs;
            int          guard;
            d   = $urandom;
            rem = msg.size() - 4 * w;
            if (rem > 4) rem = 4;
            for (int b = 0; b < rem; b++) d[31 - 8 * b -: 8] = msg[4 * w + b];
            hs    = 1'b0;
            guard = 0;
            while (!hs) begin
                @(posedge clk); #1;
                s_valid  = ($urandom_range(3) != 0);
                s_data   = s_valid ? d : $urandom;
                s_last   = s_valid ? (w == nw - 1) : 1'($urandom);
                s_nbytes = (s_valid && w == nw - 1) ? 2'(rem) : 2'($urandom);
                @(negedge clk);
                hs = s_valid && s_ready;
                guard++;
                if (guard > 3000) give_up("word_accept");
            end
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        while (done_cnt != exp_done) begin
            @(negedge clk);
            guard++;
            if (guard > 5000) give_up("done_wait");
        end
        @(negedge clk);
        check("len_ovf", len_ovf, ovf_exp);
    endtask

    function automatic void make_msg(input int len, output byte unsigned m[$]);
        m = {};
        for (int i = 0; i < len; i++) begin
            if (len == 3) m.push_back(byte'(8'h61 + i));
            else if (len == 64) m.push_back(byte'(8'h61 + (i % 4)));
            else m.push_back(byte'($urandom));
        end
    endfunction

    // Monitor plus core model: checks issued blocks, then emulates core busy.
    initial begin : monitor
        blk_t       cur;
        int         cnt;
        logic [3:0] nxt;
        nxt = '0;
        cnt = 0;
        cur = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                mon_phase = 0;
                nxt       = '0;
            end else begin
                if (done) begin
                    done_cnt++;
                    check("done_after_final", 32'(last_fin), 1);
                    last_fin = 1'b0;
`ifdef SM3_PAD_AUTO_READ_EN
                    check("done_read_cmd", {core_cmd_w, core_cmd}, 4'b1001);
`else
                    check("done_no_cmd", core_cmd_w, 0);
`endif
                end
                case (mon_phase)
                    0: begin
                        if (core_cmd_w && core_cmd[1]) begin
                            if (exp_q.size() == 0) begin
                                n_cmp++;
                                n_err++;
                                $display("FAIL unexpected_block: cmd %b, none expected", core_cmd);
                                cur = '0;
                            end else begin
                                cur = exp_q.pop_front();
                                check("issue_cmd", core_cmd, cur.cmd);
                            end
                            check("issue_ready", s_ready, 0);
                            last_fin  = cur.fin;
                            mon_k     = 0;
                            mon_phase = 1;
                        end else if (core_cmd_w) begin
`ifdef SM3_PAD_AUTO_READ_EN
                            check("read_with_done", done, 1);
`else
                            n_cmp++;
                            n_err++;
                            $display("FAIL stray_cmd: cmd %b with cmd_w, none expected", core_cmd);
`endif
                        end
                    end
                    1: begin
                        check($sformatf("blk_w%0d", mon_k), core_din,
                              cur.data[511 - 32 * mon_k -: 32]);
                        check("stream_ready", s_ready, 0);
                        mon_k++;
                        if (mon_k == 16) begin
                            mon_phase = 2;
                            cnt       = $urandom_range(3);
                        end
                    end
                    2: begin
                        check("wait_ready", s_ready, 0);
                        check("idle_din", core_din, 0);
                        if (cnt == 0) begin
                            nxt       = {1'b1, 3'($urandom)};
                            cnt       = $urandom_range(5, 1);
                            mon_phase = 3;
                        end else begin
                            cnt--;
                        end
                    end
                    default: begin
                        check("busy_ready", s_ready, 0);
                        if (cnt == 0) begin
                            nxt       = {1'b0, 3'($urandom)};
                            mon_phase = 0;
                        end else begin
                            cnt--;
                        end
                    end
                endcase
            end
            @(posedge clk); #1;
            core_status = reset ? nxt : 4'h0;
        end
    end

    initial begin : watchdog
        #500000;
        give_up("global");
    end

    initial begin : stimulus
        byte unsigned m[$];
        int           dl[14] = '{3, 64, 56, 55, 57, 60, 61, 63, 1, 4, 52, 53, 119, 120};
        int           guard;

        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", s_ready, 0);
        check("rst_cmd_w", core_cmd_w, 0);
        check("rst_cmd", core_cmd, 0);
        check("rst_din", core_din, 0);
        check("rst_done", done, 0);
        check("rst_len_ovf", len_ovf, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ready_after_reset", s_ready, 1);

        foreach (dl[i]) begin
            make_msg(dl[i], m);
            send_msg(m);
            wait_done();
        end
        for (int i = 0; i < 8; i++) begin
            make_msg($urandom_range(150, 1), m);
            send_msg(m);
            wait_done();
        end
        // 520 bytes = 4160 bits wraps the 12-bit counter.
        make_msg(520, m);
        send_msg(m);
        wait_done();

        // Abort an "abc" block mid-stream.
        make_msg(3, m);
        send_msg(m);
        guard = 0;
        while (!(mon_phase == 1 && mon_k == 6)) begin
            @(negedge clk); #1;
            guard++;
            if (guard > 3000) give_up("stream_wait");
        end
        #2;
        reset = 1'b0;
        #1;
        check("abort_s_ready", s_ready, 0);
        check("abort_cmd_w", core_cmd_w, 0);
        check("abort_cmd", core_cmd, 0);
        check("abort_din", core_din, 0);
        check("abort_done", done, 0);
        check("abort_len_ovf", len_ovf, 0);
        exp_q.delete();
        exp_done--;
        last_fin = 1'b0;
        ovf_exp  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        make_msg(3, m);
        send_msg(m);
        wait_done();
        for (int i = 0; i < 4; i++) begin
            make_msg($urandom_range(130, 1), m);
            send_msg(m);
            wait_done();
        end

        repeat (10) @(negedge clk);
        check("exp_queue_empty", exp_q.size(), 0);
        check("done_count", done_cnt, exp_done);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
